apb_master_bridge: RTL and testbench

- Requester end of the team's APB link; the RTL counterpart to the TB driver role on the APB slave interface.
- Accepts single read/write commands over a valid/ready command port and runs each as an APB SETUP→ACCESS transfer.
- Returns read data and error status on a valid/ready response port.
- Sits between the core-side register-access logic and any APB slave, including the slave DUT.

---
 rtl/apb_master_bridge.sv | 154 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB requester bridge: runs one valid/ready command at a time as an APB
// SETUP/ACCESS transfer and returns the read data and status on a valid/ready
// response port. A timeout aborts the transfer if the slave stalls too long.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module apb_master_bridge #(
  parameter int unsigned DATA_WIDTH     = `DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = `ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Counter value seen in the last permitted stalled ACCESS cycle.
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e                  state_q, state_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_error_q, rsp_error_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;

  // Accept a command only while idle and out of reset.
  assign cmd_ready = (state_q == IDLE) && !PRESET;

  // Next-state and next-output logic for the transfer sequence.
  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_cnt_d    = wait_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d    = SETUP;
          pwrite_d   = cmd_write;
          paddr_d    = cmd_addr;
          pwdata_d   = cmd_write ? cmd_wdata : '0;
          wait_cnt_d = '0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d       = RESP;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_error_d   = PSLVERR;
          rsp_timeout_d = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          if ((TIMEOUT_CYCLES != 0) && (wait_cnt_q == TO_LAST)) begin
            state_d       = RESP;
            rsp_rdata_d   = '0;
            rsp_error_d   = 1'b1;
            rsp_timeout_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Testbench for apb_master_bridge: directed and randomized transfers checked
// against a transfer-level reference model of the APB requester behaviour.
module tb_apb_master_bridge;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 4;

  logic          PCLK;
  logic          PRESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          rsp_timeout;
  logic          PSEL;
  logic          PENABLE;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int checks = 0;
  int errors = 0;

  apb_master_bridge #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .rsp_timeout(rsp_timeout),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PADDR      (PADDR),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // One complete transfer. err_mode: 0 PSLVERR=0, 1 PSLVERR=1, 2 random.
  // pend keeps a junk command valid while the transfer is in flight.
  task automatic run_xfer(input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [DW-1:0] rd_done,
                          input int waits, input int rdly, input bit pend,
                          input int err_mode);
    logic [DW-1:0]  exp_wd, rd, exp_rd;
    logic           se, exp_err, exp_to;
    logic [AW+DW+4:0] act_a, exp_a;
    logic [AW+2*DW+6:0] act_r, exp_r;
    int n_acc;
    // Reference model: transfer completes on the first ready ACCESS cycle,
    // unless TO stalled ACCESS cycles come first.
    exp_wd = wr ? wd : '0;
    exp_to = (waits >= int'(TO));
    n_acc  = exp_to ? int'(TO) : waits + 1;
    rd = '0;
    se = 1'b0;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
    end
    tick();

    // SETUP: PREADY/PSLVERR asserted here must have no effect.
    cmd_valid = pend; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = $urandom;
    act_a = {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, cmd_ready};
    exp_a = {1'b1, 1'b0, wr, addr, exp_wd, 1'b0, 1'b0};
    checks++;
    if (act_a !== exp_a) begin
      errors++;
      $display("FAIL setup_phase: got %h want %h", act_a, exp_a);
    end
    tick();

    // ACCESS cycles.
    for (int i = 0; i < n_acc; i++) begin
      rd = (i == waits) ? rd_done : $urandom;
      case (err_mode)
        0:       se = 1'b0;
        1:       se = 1'b1;
        default: se = 1'($urandom);
      endcase
      if (i != waits) se = 1'($urandom);
      PREADY = (i == waits); PRDATA = rd; PSLVERR = se;
      act_a = {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, cmd_ready};
      exp_a = {1'b1, 1'b1, wr, addr, exp_wd, 1'b0, 1'b0};
      checks++;
      if (act_a !== exp_a) begin
        errors++;
        $display("FAIL access_phase[%0d]: got %h want %h", i, act_a, exp_a);
      end
      tick();
    end
    exp_rd  = (exp_to || wr) ? '0 : rd;
    exp_err = exp_to ? 1'b1 : se;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;

    // RESP with optional backpressure.
    for (int j = 0; j <= rdly; j++) begin
      act_r = {rsp_valid, rsp_rdata, rsp_error, rsp_timeout, PSEL, PENABLE,
               cmd_ready, PADDR, PWRITE, PWDATA};
      exp_r = {1'b1, exp_rd, exp_err, exp_to, 1'b0, 1'b0,
               1'b0, addr, wr, exp_wd};
      checks++;
      if (act_r !== exp_r) begin
        errors++;
        $display("FAIL resp_phase[%0d]: got %h want %h", j, act_r, exp_r);
      end
      rsp_ready = (j == rdly);
      tick();
    end
    rsp_ready = 1'b0;
    if (!pend) cmd_valid = 1'b0;

    act_a = '0;
    act_a[2:0] = {rsp_valid, PSEL, cmd_ready};
    exp_a = '0;
    exp_a[2:0] = 3'b001;
    checks++;
    if (act_a !== exp_a) begin
      errors++;
      $display("FAIL back_to_idle: got rsp_valid/PSEL/cmd_ready=%b want 001", act_a[2:0]);
    end
  endtask

  task automatic test_reset();
    logic [AW+2*DW+7:0] act, exp_v;
    PRESET = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 32'h0000_0040; cmd_wdata = 32'hFFFF_FFFF;
    rsp_ready = 1'b0; PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hA5A5_A5A5;
    tick();
    tick();
    act = {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata,
           rsp_error, rsp_timeout, cmd_ready};
    exp_v = '0;
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", act, exp_v);
    end
    PRESET = 1'b0; cmd_valid = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick();
    checks++;
    if ({PSEL, rsp_valid, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_release: got PSEL/rsp_valid/cmd_ready=%b want 001",
               {PSEL, rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_write_zero_wait();
    run_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 0, 1'b0, 0);
  endtask

  task automatic test_read_waits();
    // Completes on the 4th ACCESS cycle, which is also the last before timeout.
    run_xfer(1'b0, 32'h0000_0024, 32'hFFFF_0000, 32'h1234_5678, 3, 0, 1'b0, 0);
  endtask

  task automatic test_slave_error();
    run_xfer(1'b1, 32'h0000_0030, 32'h5555_AAAA, 32'h0, 0, 0, 1'b0, 1);
    run_xfer(1'b0, 32'h0000_0034, 32'h0, 32'hCAFE_0001, 1, 0, 1'b0, 1);
  endtask

  task automatic test_timeout();
    run_xfer(1'b0, 32'h0000_0050, 32'h0, 32'h7777_7777, 4, 0, 1'b0, 2);
    run_xfer(1'b1, 32'h0000_0054, 32'h1357_9BDF, 32'h0, 9, 1, 1'b0, 2);
  endtask

  task automatic test_back_to_back();
    run_xfer(1'b0, 32'h0000_0060, 32'h0, 32'h89AB_CDEF, 0, 5, 1'b1, 0);
    run_xfer(1'b1, 32'h0000_0064, 32'h2468_ACE0, 32'h0, 0, 0, 1'b1, 0);
    run_xfer(1'b0, 32'h0000_0068, 32'h0, 32'h1111_2222, 2, 0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_access();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0070; cmd_wdata = 32'h0F0F_0F0F;
    tick();
    cmd_valid = 1'b0; PREADY = 1'b0;
    tick();
    checks++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_access: got PSEL/PENABLE=%b want 11", {PSEL, PENABLE});
    end
    PRESET = 1'b1; cmd_valid = 1'b1; PREADY = 1'b1;
    tick();
    checks++;
    if ({PSEL, PENABLE, rsp_valid, PADDR, PWDATA, cmd_ready} !== '0) begin
      errors++;
      $display("FAIL reset_mid_access: got PSEL/PENABLE/rsp_valid=%b PADDR=%h cmd_ready=%b want zeros",
               {PSEL, PENABLE, rsp_valid}, PADDR, cmd_ready);
    end
    tick();
    checks++;
    if ({PSEL, rsp_valid, cmd_ready} !== 3'b000) begin
      errors++;
      $display("FAIL cmd_during_reset: got PSEL/rsp_valid/cmd_ready=%b want 000",
               {PSEL, rsp_valid, cmd_ready});
    end
    PRESET = 1'b0; cmd_valid = 1'b0; PREADY = 1'b0;
    tick();
    run_xfer(1'b0, 32'h0000_0074, 32'h0, 32'hFEED_0074, 1, 0, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      run_xfer(1'($urandom), $urandom, $urandom, $urandom,
               int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
               1'($urandom), 2);
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_waits();
    test_slave_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
